if_id_skid_reg: RTL and testbench
=================================

Name: if_id_skid_reg

Overview:
- Elastic 32-bit fetch-to-decode pipeline register with a 2-entry skid buffer and a valid/ready handshake on both sides.
- Sits between the fetch stage (PC, instruction memory) and decode, replacing a plain enable-gated DFF bank.
- Decouples decode stalls from fetch timing and supports branch flush.
- All outputs are registered; there is no combinational path from input to output or from out_ready to in_ready.

Parameters:
- WIDTH, 32, instruction width in bits.
- PCW, 32, program-counter width in bits.
- NOP, 32'h00000000, value driven on out_instr whenever out_valid=0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all buffered entries (branch/jump taken).
- in_valid  in  1  fetch presents a valid instruction.
- in_ready  out  1  buffer can accept; equals NOT skid_valid (registered state only).
- in_instr  in  WIDTH  fetched instruction.
- in_pc  in  PCW  PC of the fetched instruction.
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decode accepts this cycle.
- out_instr  out  WIDTH  instruction to decode; NOP when out_valid=0.
- out_pc  out  PCW  PC to decode; 0 when out_valid=0.
- count  out  2  occupancy: 0, 1 or 2.

Behaviour:
- Clock port is clk. Reset is synchronous and active-high, named reset, sampled only on the rising edge of clk.
- Reset: main_valid=0, skid_valid=0, main/skid data=0. Outputs after the reset edge: out_valid=0, out_instr=NOP, out_pc=0, count=0, in_ready=1.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - The producer may drop in_valid at any time; this block never depends on input stability.
- States (count):
  - EMPTY (0):
    - in_fire -> ONE; main loads in.
  - ONE (1):
    - in_fire & out_fire -> ONE; main loads in.
    - in_fire only -> FULL; skid loads in.
    - out_fire only -> EMPTY.
    - neither -> hold.
  - FULL (2), in_ready=0:
    - out_fire -> ONE; main loads skid; skid_valid clears.
    - otherwise hold.
- Ordering is strict FIFO: skid content always enters main before any newer word.
- Latency: in_fire at edge N makes the entry visible on out_* after edge N (1 cycle). Sustained throughput is 1 word/cycle with out_ready held high.
- Stability: while out_valid=1 and out_ready=0, out_instr and out_pc hold unchanged.
- Flush:
  - Next state is EMPTY. The word accepted in the same cycle is discarded; in_ready is still 1 that cycle, so fetch sees the word as accepted.
  - An out_fire in the flush cycle still counts as consumed by decode.
  - Data registers need not clear; outputs are masked to NOP/0.
- Priority: reset > flush > normal transitions.
- Reset or flush mid-FULL drops both entries. in_ready returns to 1 on the next cycle.
- count is never 3. No overflow is possible because in_ready is deasserted in FULL.
- Assertion for the verifier: count == main_valid + skid_valid at every cycle.

Test Plan:
- Reset, then drive in_valid=1, in_instr=32'h8C080004, in_pc=32'h00000000, out_ready=1 -> next cycle out_valid=1, out_instr=32'h8C080004, out_pc=0, count=1.
- Stream 4 words (PC 0,4,8,C) with out_ready=1 -> the same 4 words appear in order on consecutive cycles; in_ready stays 1; count stays at most 1.
- Push A (PC 10) then B (PC 14) with out_ready=0 -> count=2, in_ready=0, out_instr=A held. Raise out_ready -> A, then B on the following cycle; count goes 2 to 1 to 0.
- With count=2, assert flush for 1 cycle while in_valid=1 with C -> next cycle out_valid=0, out_instr=NOP, count=0, in_ready=1; C is never emitted.
- Assert reset while count=1 and in_fire is present -> next cycle count=0, out_valid=0, out_pc=0. The first word pushed afterwards emerges with 1-cycle latency.
- Random valid/ready for 1000 cycles against a scoreboard queue -> no loss, duplication or reorder. out_* is stable whenever out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// Fetch-to-decode elastic pipeline register: a main output slot plus one skid slot,
// valid/ready on both sides, branch flush, and purely registered outputs.
module if_id_skid_reg #(
    parameter int                 WIDTH = 32,
    parameter int                 PCW   = 32,
    parameter logic [WIDTH-1:0]   NOP   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_instr,
    input  logic [PCW-1:0]   in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [PCW-1:0]   out_pc,
    output logic [1:0]       count
);

    logic             main_valid_reg, main_valid_next;
    logic             skid_valid_reg, skid_valid_next;
    logic [WIDTH-1:0] main_instr_reg, main_instr_next;
    logic [PCW-1:0]   main_pc_reg,    main_pc_next;
    logic [WIDTH-1:0] skid_instr_reg, skid_instr_next;
    logic [PCW-1:0]   skid_pc_reg,    skid_pc_next;

    logic in_fire;
    logic out_fire;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready = ~skid_valid_reg;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid_reg & out_ready;

    always_comb begin
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        main_instr_next = main_instr_reg;
        main_pc_next    = main_pc_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;

        if (flush) begin
            // Data is left in place; the cleared valid bits mask it on the outputs.
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!main_valid_reg) begin
            if (in_fire) begin
                main_valid_next = 1'b1;
                main_instr_next = in_instr;
                main_pc_next    = in_pc;
            end
        end else if (!skid_valid_reg) begin
            if (in_fire && out_fire) begin
                main_instr_next = in_instr;
                main_pc_next    = in_pc;
            end else if (in_fire) begin
                skid_valid_next = 1'b1;
                skid_instr_next = in_instr;
                skid_pc_next    = in_pc;
            end else if (out_fire) begin
                main_valid_next = 1'b0;
            end
        end else if (out_fire) begin
            // Older skid word moves forward before any new word can be taken.
            main_instr_next = skid_instr_reg;
            main_pc_next    = skid_pc_reg;
            skid_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            main_instr_reg <= '0;
            main_pc_reg    <= '0;
            skid_instr_reg <= '0;
            skid_pc_reg    <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            main_instr_reg <= main_instr_next;
            main_pc_reg    <= main_pc_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
        end
    end

    assign out_valid = main_valid_reg;
    assign count     = skid_valid_reg ? 2'd2 : {1'b0, main_valid_reg};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_instr_mask
            assign out_instr[gi] = main_valid_reg ? main_instr_reg[gi] : NOP[gi];
        end
        for (gi = 0; gi < PCW; gi = gi + 1) begin : g_pc_mask
            assign out_pc[gi] = main_valid_reg & main_pc_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: the driver queues accepted words, and the
// monitor pops and compares on every decode-side handshake.
module tb_if_id_skid_reg;

    localparam logic [31:0] NOP_V = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  count;

    int errors = 0;
    int checks = 0;
    bit init_done = 1'b0;
    logic [63:0] sb_q[$];

    if_id_skid_reg dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; returns at posedge+1 with the scoreboard updated.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic rs);
        logic fire;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(negedge clk);
        fire = iv & in_ready;
        @(posedge clk);
        #1;
        if (rs || fl) sb_q.delete();
        else if (fire) sb_q.push_back({ins, pc});
        $display("step iv=%0b instr=%h pc=%h ordy=%0b flush=%0b reset=%0b fire=%0b -> count=%0d",
                 iv, ins, pc, ordy, fl, rs, fire, count);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    logic        hold_pending = 1'b0;
    logic        prev_squash = 1'b0;
    logic [31:0] held_instr = '0;
    logic [31:0] held_pc = '0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (init_done && !reset) begin
            chk("count_vs_model", {62'd0, count}, 64'(sb_q.size()));
            chk("in_ready_vs_model", {63'd0, in_ready}, {63'd0, sb_q.size() < 2});
            chk("out_valid_vs_model", {63'd0, out_valid}, {63'd0, sb_q.size() != 0});
            if (!out_valid) begin
                chk("idle_instr_nop", {32'd0, out_instr}, {32'd0, NOP_V});
                chk("idle_pc_zero", {32'd0, out_pc}, 64'd0);
            end
            if (hold_pending && !prev_squash) begin
                chk("stall_instr_stable", {32'd0, out_instr}, {32'd0, held_instr});
                chk("stall_pc_stable", {32'd0, out_pc}, {32'd0, held_pc});
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_underflow: got word %h/%h expected none", out_instr, out_pc);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_instr", {32'd0, out_instr}, {32'd0, e[63:32]});
                    chk("out_pc", {32'd0, out_pc}, {32'd0, e[31:0]});
                    $display("pop instr=%h pc=%h", out_instr, out_pc);
                end
            end
        end
        hold_pending = out_valid & ~out_ready;
        held_instr   = out_instr;
        held_pc      = out_pc;
        prev_squash  = flush | reset;
    end

    initial begin
        @(posedge clk);
        #1;
        step(0, '0, '0, 0, 0, 1);
        step(0, '0, '0, 0, 0, 1);
        init_done = 1'b1;
        chk("rst_count", {62'd0, count}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_out_pc", {32'd0, out_pc}, 64'd0);

        // Single word, one-cycle latency.
        step(1, 32'h8C080004, 32'h0, 1, 0, 0);
        chk("first_valid", {63'd0, out_valid}, 64'd1);
        chk("first_instr", {32'd0, out_instr}, 64'h8C080004);
        chk("first_pc", {32'd0, out_pc}, 64'd0);
        chk("first_count", {62'd0, count}, 64'd1);

        // Streaming at full rate.
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h11110000 + 32'(i), 32'(i * 4), 1, 0, 0);
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
            chk("stream_count_le1", {63'd0, count <= 2'd1}, 64'd1);
            chk("stream_instr", {32'd0, out_instr}, {32'd0, 32'h11110000 + 32'(i)});
        end
        step(0, '0, '0, 1, 0, 0);
        chk("stream_drained", {62'd0, count}, 64'd0);

        // Fill the skid under backpressure, then drain in order.
        step(1, 32'hAAAA0001, 32'h10, 0, 0, 0);
        step(1, 32'hBBBB0002, 32'h14, 0, 0, 0);
        chk("full_count", {62'd0, count}, 64'd2);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_head", {32'd0, out_instr}, 64'hAAAA0001);
        step(1, 32'hDEADDEAD, 32'h99, 0, 0, 0);
        chk("full_hold_head", {32'd0, out_instr}, 64'hAAAA0001);
        step(0, '0, '0, 1, 0, 0);
        chk("drain1_count", {62'd0, count}, 64'd1);
        chk("drain1_instr", {32'd0, out_instr}, 64'hBBBB0002);
        step(0, '0, '0, 1, 0, 0);
        chk("drain2_count", {62'd0, count}, 64'd0);

        // Flush while full, with a word offered.
        step(1, 32'hAAAA0003, 32'h20, 0, 0, 0);
        step(1, 32'hBBBB0004, 32'h24, 0, 0, 0);
        step(1, 32'hCCCC0005, 32'h28, 0, 1, 0);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_instr", {32'd0, out_instr}, {32'd0, NOP_V});
        chk("flush_count", {62'd0, count}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        step(0, '0, '0, 1, 0, 0);
        chk("flush_stays_empty", {63'd0, out_valid}, 64'd0);

        // Reset with one entry held and a word firing.
        step(1, 32'hD0D0D0D0, 32'h30, 0, 0, 0);
        step(1, 32'hE0E0E0E0, 32'h34, 1, 0, 1);
        chk("midrst_count", {62'd0, count}, 64'd0);
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_pc", {32'd0, out_pc}, 64'd0);
        step(1, 32'hF0F0F0F0, 32'h38, 1, 0, 0);
        chk("postrst_instr", {32'd0, out_instr}, 64'hF0F0F0F0);
        chk("postrst_pc", {32'd0, out_pc}, 64'h38);
        step(0, '0, '0, 1, 0, 0);

        // Random handshakes against the scoreboard.
        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom(), 32'h1000 + 32'(i * 4),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(0, '0, '0, 1, 0, 0);
        chk("final_count", {62'd0, count}, 64'd0);
        chk("final_queue_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
